// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - single-port DataMemory arbiter between CPU MEM stage and AUX master
//
// Purpose: shares DataMemory between the pipeline MEM stage (priority) and the
// vector/encryption load-store unit (valid/ready). AUX is forced a slot after
// MAX_WAIT consecutive refusals, stalling the CPU for that one cycle. Read data
// (1-cycle latency) is routed back to whichever port issued the read.
//
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_cpu_req/we/addr/wdata           CPU request
//   o_cpu_stall                       CPU request not taken this cycle
//   o_cpu_rvalid, o_cpu_rdata         CPU read return (rdata held after rvalid)
//   i_aux_valid/we/addr/wdata         AUX request, o_aux_ready = accepted
//   o_aux_rvalid, o_aux_rdata         AUX read return (rdata held after rvalid)
//   o_mem_addr/wdata/wren, i_mem_q    DataMemory port A
module data_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_stall,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_aux_valid,
  output logic              o_aux_ready,
  input  logic              i_aux_we,
  input  logic [ADDR_W-1:0] i_aux_addr,
  input  logic [DATA_W-1:0] i_aux_wdata,
  output logic              o_aux_rvalid,
  output logic [DATA_W-1:0] o_aux_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_q
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CPU_RD = 2'd1;
  localparam logic [1:0] S_AUX_RD = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CW-1:0]     r_wait_cnt;
  logic [DATA_W-1:0] r_cpu_hold;
  logic [DATA_W-1:0] r_aux_hold;
  logic              w_force;
  logic              w_gnt_aux;
  logic              w_gnt_cpu;

  // Grants are gated by reset so nothing reaches the memory while rst is high.
  assign w_force   = (r_wait_cnt == MAX_CNT);
  assign w_gnt_aux = ~i_rst & i_aux_valid & (~i_cpu_req | w_force);
  assign w_gnt_cpu = ~i_rst & i_cpu_req & ~w_gnt_aux;

  assign o_aux_ready = w_gnt_aux;
  assign o_cpu_stall = i_cpu_req & w_gnt_aux;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wren  = 1'b0;
    if (w_gnt_aux) begin
      o_mem_addr  = i_aux_addr;
      o_mem_wdata = i_aux_wdata;
      o_mem_wren  = i_aux_we;
    end else if (w_gnt_cpu) begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
      o_mem_wren  = i_cpu_we;
    end
  end

  // State records who owns the data that i_mem_q will carry next cycle.
  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_gnt_cpu && !i_cpu_we)
      w_state_nxt = S_CPU_RD;
    else if (w_gnt_aux && !i_aux_we)
      w_state_nxt = S_AUX_RD;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_cpu_hold <= '0;
      r_aux_hold <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!i_aux_valid || w_gnt_aux)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != MAX_CNT)
        r_wait_cnt <= r_wait_cnt + CW'(1);
      if (r_state == S_CPU_RD)
        r_cpu_hold <= i_mem_q;
      if (r_state == S_AUX_RD)
        r_aux_hold <= i_mem_q;
    end
  end

  assign o_cpu_rvalid = (r_state == S_CPU_RD);
  assign o_aux_rvalid = (r_state == S_AUX_RD);
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_q : r_cpu_hold;
  assign o_aux_rdata  = o_aux_rvalid ? i_mem_q : r_aux_hold;

endmodule
